// File: rtl/rv_mem_arbiter.sv
// ============================================================================
// Module   : rv_mem_arbiter
// Brief    : Shares one single-port BRAM between instruction fetch and data
//            ports. Data has priority; the optional starvation guard is
//            enabled with the macro RVARB_STARVE_GUARD_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rv_mem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int READ_LAT   = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_gnt,
   output logic          i_rvalid,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_wea,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   generate
      if (READ_LAT < 1 || READ_LAT > 4 || STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_param
         $error("rv_mem_arbiter: READ_LAT must be 1..4 and STARVE_MAX 1..7");
      end
   endgenerate

   logic                force_i;
   logic [AW-1:0]       mem_addr_q;
   logic [AW-1:0]       mem_addr_d;
   logic [READ_LAT-1:0] tag_vld_q;
   logic [READ_LAT-1:0] tag_vld_d;
   logic [READ_LAT-1:0] tag_own_q;
   logic [READ_LAT-1:0] tag_own_d;

   // Grants are gated by reset so nothing reaches the BRAM while rst is low.
   assign d_gnt = rst & d_req & ~force_i;
   assign i_gnt = rst & i_req & (~d_req | force_i);

`ifdef RVARB_STARVE_GUARD_EN
   logic [2:0] starve_cnt_q;
   logic [2:0] starve_cnt_d;

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!i_req || i_gnt) begin
         starve_cnt_d = 3'd0;
      end else if (d_gnt && (starve_cnt_q != 3'd7)) begin
         starve_cnt_d = starve_cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt_q <= 3'd0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign force_i = (starve_cnt_q == 3'(STARVE_MAX)) & i_req;
`else
   assign force_i = 1'b0;
`endif

   assign mem_en  = i_gnt | d_gnt;
   assign mem_wea = d_gnt & d_we;
   assign mem_din = d_gnt ? d_wdata : '0;

   // With no grant the address bus parks on the last granted address.
   always_comb begin
      mem_addr_d = mem_addr_q;
      if (d_gnt) begin
         mem_addr_d = d_addr;
      end else if (i_gnt) begin
         mem_addr_d = i_addr;
      end
   end

   assign mem_addr = mem_addr_d;

   always_comb begin
      tag_vld_d    = tag_vld_q;
      tag_own_d    = tag_own_q;
      tag_vld_d[0] = i_gnt | (d_gnt & ~d_we);
      tag_own_d[0] = d_gnt;
      for (int i = 1; i < READ_LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_own_d[i] = tag_own_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_addr_q <= '0;
         tag_vld_q  <= '0;
         tag_own_q  <= '0;
      end else begin
         mem_addr_q <= mem_addr_d;
         tag_vld_q  <= tag_vld_d;
         tag_own_q  <= tag_own_d;
      end
   end

   assign i_rvalid = tag_vld_q[READ_LAT-1] & ~tag_own_q[READ_LAT-1];
   assign d_rvalid = tag_vld_q[READ_LAT-1] &  tag_own_q[READ_LAT-1];
   assign rdata    = mem_dout;

endmodule

`default_nettype wire

// File: tb/tb_rv_mem_arbiter.sv
// ============================================================================
// Module   : tb_rv_mem_arbiter
// Brief    : Directed self-checking bench for rv_mem_arbiter (READ_LAT 1 and 3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rv_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        rst3;
   logic        i_req;
   logic [31:0] i_addr;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] mem_dout;

   logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_wea;
   logic [31:0] rdata, mem_addr, mem_din;

   logic        i3_gnt, i3_rvalid, d3_gnt, d3_rvalid, mem3_en, mem3_wea;
   logic [31:0] rdata3, mem3_addr, mem3_din;

   int n_cmp = 0;
   int n_err = 0;
   bit guard_on;

   rv_mem_arbiter #(.AW(32), .DW(32), .READ_LAT(1), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata),
      .mem_en(mem_en), .mem_wea(mem_wea), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   rv_mem_arbiter #(.AW(32), .DW(32), .READ_LAT(3), .STARVE_MAX(4)) dut3 (
      .clk(clk), .rst(rst3),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i3_gnt), .i_rvalid(i3_rvalid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d3_gnt), .d_rvalid(d3_rvalid), .rdata(rdata3),
      .mem_en(mem3_en), .mem_wea(mem3_wea), .mem_addr(mem3_addr),
      .mem_din(mem3_din), .mem_dout(mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
`ifdef RVARB_STARVE_GUARD_EN
      guard_on = 1'b1;
`else
      guard_on = 1'b0;
`endif
      rst = 1'b0; rst3 = 1'b0;
      i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0;
      d_addr = 32'h0; d_wdata = 32'h0; mem_dout = 32'h0;

      // Reset held with both requests active
      tick(); tick();
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_i_gnt", i_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_wea", mem_wea, 0);
      chk("rst_i_rvalid", i_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_mem_addr", mem_addr, 0);

      // Release: data is granted straight away
      rst = 1'b1; rst3 = 1'b1; d_addr = 32'h300;
      #1;
      chk("rel_d_gnt", d_gnt, 1);
      chk("rel_i_gnt", i_gnt, 0);
      chk("rel_mem_addr", mem_addr, 32'h300);
      tick();
      i_req = 1'b0; d_req = 1'b0;
      #1;
      chk("rel_d_rvalid", d_rvalid, 1);
      chk("idle_mem_en", mem_en, 0);
      chk("idle_addr_hold", mem_addr, 32'h300);
      tick();
      chk("idle_d_rvalid", d_rvalid, 0);

      // Lone fetch
      i_req = 1'b1; i_addr = 32'h100;
      #1;
      chk("fetch_i_gnt", i_gnt, 1);
      chk("fetch_mem_addr", mem_addr, 32'h100);
      chk("fetch_mem_din", mem_din, 0);
      chk("fetch_mem_wea", mem_wea, 0);
      tick();
      i_req = 1'b0; mem_dout = 32'hDEADBEEF;
      #1;
      chk("fetch_i_rvalid", i_rvalid, 1);
      chk("fetch_rdata", rdata, 32'hDEADBEEF);
      chk("fetch_d_rvalid", d_rvalid, 0);
      tick();
      chk("fetch_i_rvalid_end", i_rvalid, 0);

      // Conflict: data first, then fetch
      i_req = 1'b1; i_addr = 32'h104; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      #1;
      chk("conf_d_gnt", d_gnt, 1);
      chk("conf_i_gnt", i_gnt, 0);
      chk("conf_mem_addr", mem_addr, 32'h200);
      tick();
      d_req = 1'b0;
      #1;
      chk("conf_i_gnt2", i_gnt, 1);
      chk("conf_mem_addr2", mem_addr, 32'h104);
      chk("conf_d_rvalid", d_rvalid, 1);
      chk("conf_i_rvalid0", i_rvalid, 0);
      tick();
      i_req = 1'b0;
      #1;
      chk("conf_i_rvalid", i_rvalid, 1);
      chk("conf_d_rvalid2", d_rvalid, 0);
      tick();

      // Write: no response pulse
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
      #1;
      chk("wr_d_gnt", d_gnt, 1);
      chk("wr_mem_wea", mem_wea, 1);
      chk("wr_mem_din", mem_din, 32'h12345678);
      chk("wr_mem_addr", mem_addr, 32'h40);
      tick();
      d_req = 1'b0; d_we = 1'b0;
      #1;
      chk("wr_d_rvalid", d_rvalid, 0);
      chk("wr_i_rvalid", i_rvalid, 0);
      tick();
      chk("wr_d_rvalid2", d_rvalid, 0);

      // Starvation: both held for 10 cycles
      i_req = 1'b1; i_addr = 32'h108; d_req = 1'b1; d_addr = 32'h20C;
      for (int k = 0; k < 10; k++) begin
         #1;
         chk($sformatf("starve_i_gnt_%0d", k), i_gnt, (guard_on && (k % 5 == 4)) ? 1 : 0);
         chk($sformatf("starve_d_gnt_%0d", k), d_gnt, (guard_on && (k % 5 == 4)) ? 0 : 1);
         tick();
      end
      i_req = 1'b0; d_req = 1'b0;
      tick(); tick(); tick(); tick();

      // READ_LAT=3 latency
      i_req = 1'b1; i_addr = 32'h180;
      #1;
      chk("l3_i_gnt", i3_gnt, 1);
      tick();
      i_req = 1'b0;
      chk("l3_rv_n1", i3_rvalid, 0);
      tick();
      chk("l3_rv_n2", i3_rvalid, 0);
      tick();
      chk("l3_rv_n3", i3_rvalid, 1);
      tick();
      chk("l3_rv_n4", i3_rvalid, 0);

      // READ_LAT=3 reset while fetch in flight
      i_req = 1'b1; i_addr = 32'h184;
      #1;
      chk("rif_i_gnt", i3_gnt, 1);
      tick();
      i_req = 1'b0; rst3 = 1'b0;
      #1;
      chk("rif_rv_rst", i3_rvalid, 0);
      tick();
      rst3 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("rif_rv_%0d", k), i3_rvalid, 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
